// File: rtl/dmem_arbiter_if.sv
// Bundle between the two CPU memory-request ports, the arbiter and Data_Memory.
// Signal suffixes are from the arbiter's point of view.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
);
   logic              req0_i;
   logic              we0_i;
   logic [ADDR_W-1:0] addr0_i;
   logic [DATA_W-1:0] wdata0_i;
   logic              ack0_o;
   logic [DATA_W-1:0] rdata0_o;

   logic              req1_i;
   logic              we1_i;
   logic [ADDR_W-1:0] addr1_i;
   logic [DATA_W-1:0] wdata1_i;
   logic              ack1_o;
   logic [DATA_W-1:0] rdata1_o;

   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_read_o;
   logic              mem_write_o;
   logic [DATA_W-1:0] mem_rdata_i;

   logic              busy_o;
   logic [CNT_W-1:0]  conflict_cnt_o;

   modport slave (
      input  req0_i, we0_i, addr0_i, wdata0_i,
      input  req1_i, we1_i, addr1_i, wdata1_i,
      input  mem_rdata_i,
      output ack0_o, rdata0_o, ack1_o, rdata1_o,
      output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
      output busy_o, conflict_cnt_o
   );

   modport master (
      output req0_i, we0_i, addr0_i, wdata0_i,
      output req1_i, we1_i, addr1_i, wdata1_i,
      output mem_rdata_i,
      input  ack0_o, rdata0_o, ack1_o, rdata1_o,
      input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
      input  busy_o, conflict_cnt_o
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one Data_Memory port between two pipelined CPUs.
// IDLE/RESP arbitrate, ACCESS drives the latched command for exactly one cycle.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input logic           clk_i,
   input logic           rst_i,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic              port;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            state_q, state_d;
   cmd_t              cmd_q, cmd_d;
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              elig0, elig1;
   logic              do_grant;
   logic              grant_port;

   logic              ack0_q, ack1_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic              mem_read_q, mem_write_q;
   logic              busy_q;

   // Next-state, arbitration and command latch selection
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      do_grant     = 1'b0;
      grant_port   = 1'b0;

      // The port being acked may still hold req high, so it sits out this round
      elig0 = bus.req0_i && !((state_q == RESP) && !cmd_q.port);
      elig1 = bus.req1_i && !((state_q == RESP) &&  cmd_q.port);

      case (state_q)
         IDLE, RESP: begin
            if (elig0 && elig1) begin
               do_grant   = 1'b1;
               grant_port = !last_grant_q;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (elig0 || elig1) begin
               do_grant   = 1'b1;
               grant_port = elig1;
            end

            if (do_grant) begin
               state_d      = ACCESS;
               last_grant_d = grant_port;
               cmd_d.port   = grant_port;
               cmd_d.we     = grant_port ? bus.we1_i    : bus.we0_i;
               cmd_d.addr   = grant_port ? bus.addr1_i  : bus.addr0_i;
               cmd_d.wdata  = grant_port ? bus.wdata1_i : bus.wdata0_i;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS:  state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // State, latch and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;

         busy_q       <= (state_d == ACCESS);
         mem_read_q   <= (state_d == ACCESS) && !cmd_d.we;
         mem_write_q  <= (state_d == ACCESS) &&  cmd_d.we;

         ack0_q       <= (state_q == ACCESS) && !cmd_q.port;
         ack1_q       <= (state_q == ACCESS) &&  cmd_q.port;

         // Read data lands at the edge closing ACCESS; the other port keeps its value
         if ((state_q == ACCESS) && !cmd_q.we) begin
            if (cmd_q.port) begin
               rdata1_q <= bus.mem_rdata_i;
            end else begin
               rdata0_q <= bus.mem_rdata_i;
            end
         end
      end
   end

   // Command latch only changes on a grant, so it doubles as the held memory bus
   assign bus.mem_addr_o     = cmd_q.addr;
   assign bus.mem_wdata_o    = cmd_q.wdata;
   assign bus.mem_read_o     = mem_read_q;
   assign bus.mem_write_o    = mem_write_q;
   assign bus.busy_o         = busy_q;
   assign bus.ack0_o         = ack0_q;
   assign bus.ack1_o         = ack1_q;
   assign bus.rdata0_o       = rdata0_q;
   assign bus.rdata1_o       = rdata1_q;
   assign bus.conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read memory model.
module tb_dmem_arbiter;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   logic clk_i;
   logic rst_i;
   int   checks;
   int   errors;

   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Memory: written words come from the array, untouched words read a pattern
   logic [DATA_W-1:0] tbmem    [256];
   logic              wr_valid [256];
   logic [7:0]        midx;
   assign midx = bus.mem_addr_o[9:2];
   assign bus.mem_rdata_i = (wr_valid[midx] === 1'b1) ? tbmem[midx]
                          : {16'hC0DE, 6'd0, bus.mem_addr_o[9:0]};

   always @(posedge clk_i) begin
      if (bus.mem_write_o) begin
         tbmem[midx]    <= bus.mem_wdata_o;
         wr_valid[midx] <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Both ports request together from IDLE; each drops req the cycle after its ack
   task automatic serve_pair();
      bit got0, got1, d0, d1;
      got0 = 1'b0; got1 = 1'b0; d0 = 1'b0; d1 = 1'b0;
      bus.req0_i = 1'b1;
      bus.req1_i = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (d0) begin bus.req0_i = 1'b0; d0 = 1'b0; end
         if (d1) begin bus.req1_i = 1'b0; d1 = 1'b0; end
         if (bus.ack0_o) begin got0 = 1'b1; d0 = 1'b1; end
         if (bus.ack1_o) begin got1 = 1'b1; d1 = 1'b1; end
         if (got0 && got1 && !bus.req0_i && !bus.req1_i) break;
      end
      chk("pair_served", {28'd0, got0, got1, bus.req0_i, bus.req1_i}, 32'hC);
      tick();
   endtask

   initial begin
      int         n0, n1, nacks;
      logic [5:0] order;
      bit         drop0, drop1;

      checks = 0;
      errors = 0;
      rst_i  = 1'b1;
      bus.req0_i = 1'b0; bus.we0_i = 1'b0; bus.addr0_i = '0; bus.wdata0_i = '0;
      bus.req1_i = 1'b0; bus.we1_i = 1'b0; bus.addr1_i = '0; bus.wdata1_i = '0;

      // Reset then idle
      tick(); tick();
      rst_i = 1'b0;
      chk("rst_ack", {30'd0, bus.ack0_o, bus.ack1_o}, 32'h0);
      chk("rst_rdata0", bus.rdata0_o, 32'h0);
      chk("rst_rdata1", bus.rdata1_o, 32'h0);
      chk("rst_addr", bus.mem_addr_o, 32'h0);
      chk("rst_wdata", bus.mem_wdata_o, 32'h0);
      chk("rst_cnt", 32'(bus.conflict_cnt_o), 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_quiet", {28'd0, bus.mem_read_o, bus.mem_write_o, bus.busy_o,
                            bus.ack0_o | bus.ack1_o}, 32'h0);
      end

      // Port 0 write 0x10 <= 0xAB
      bus.req0_i = 1'b1; bus.we0_i = 1'b1; bus.addr0_i = 32'h10; bus.wdata0_i = 32'hAB;
      tick();
      chk("wr_strobe", 32'(bus.mem_write_o), 32'h1);
      chk("wr_read_low", 32'(bus.mem_read_o), 32'h0);
      chk("wr_addr", bus.mem_addr_o, 32'h10);
      chk("wr_data", bus.mem_wdata_o, 32'hAB);
      chk("wr_busy", 32'(bus.busy_o), 32'h1);
      chk("wr_ack_early", 32'(bus.ack0_o), 32'h0);
      tick();
      chk("wr_strobe_once", 32'(bus.mem_write_o), 32'h0);
      chk("wr_ack0", 32'(bus.ack0_o), 32'h1);
      chk("wr_ack1_low", 32'(bus.ack1_o), 32'h0);
      tick();
      chk("wr_ack_pulse", 32'(bus.ack0_o), 32'h0);
      chk("wr_addr_hold", bus.mem_addr_o, 32'h10);
      bus.req0_i = 1'b0; bus.we0_i = 1'b0;

      // Port 0 reads it back
      bus.req0_i = 1'b1; bus.addr0_i = 32'h10;
      tick();
      chk("rd_strobe", 32'(bus.mem_read_o), 32'h1);
      tick();
      chk("rd_ack0", 32'(bus.ack0_o), 32'h1);
      chk("rd_data0", bus.rdata0_o, 32'hAB);
      chk("rd_ack1_low", 32'(bus.ack1_o), 32'h0);
      tick();
      bus.req0_i = 1'b0;

      // Simultaneous reads straight after reset: port 0 first
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("rst2_rdata0", bus.rdata0_o, 32'h0);
      bus.addr0_i = 32'h30; bus.addr1_i = 32'h34;
      bus.req0_i = 1'b1; bus.req1_i = 1'b1;
      tick();
      chk("sim_addr0", bus.mem_addr_o, 32'h30);
      chk("sim_cnt_inc", 32'(bus.conflict_cnt_o), 32'h1);
      tick();
      chk("sim_ack0", {30'd0, bus.ack0_o, bus.ack1_o}, 32'h2);
      chk("sim_rdata0", bus.rdata0_o, 32'hC0DE0030);
      tick();
      chk("sim_addr1", bus.mem_addr_o, 32'h34);
      chk("sim_read1", 32'(bus.mem_read_o), 32'h1);
      bus.req0_i = 1'b0;
      tick();
      chk("sim_ack1", {30'd0, bus.ack0_o, bus.ack1_o}, 32'h1);
      chk("sim_rdata1", bus.rdata1_o, 32'hC0DE0034);
      chk("sim_cnt", 32'(bus.conflict_cnt_o), 32'h1);
      tick();
      bus.req1_i = 1'b0;

      // Continuous requests: strict alternation
      n0 = 0; n1 = 0; nacks = 0; order = '0; drop0 = 1'b0; drop1 = 1'b0;
      bus.req0_i = 1'b1; bus.req1_i = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (drop0) begin bus.req0_i = 1'b0; drop0 = 1'b0; end
         if (drop1) begin bus.req1_i = 1'b0; drop1 = 1'b0; end
         if (bus.ack0_o && bus.ack1_o) chk("rr_ack_excl", 32'h3, 32'h1);
         if (bus.ack0_o || bus.ack1_o) begin
            if (nacks < 6) order[nacks] = bus.ack1_o;
            nacks++;
         end
         if (bus.ack0_o) begin n0++; if (n0 == 3) drop0 = 1'b1; end
         if (bus.ack1_o) begin n1++; if (n1 == 3) drop1 = 1'b1; end
      end
      chk("rr_count", 32'(nacks), 32'd6);
      chk("rr_order", {26'd0, order}, 32'h2A);
      chk("rr_cnt", 32'(bus.conflict_cnt_o), 32'h2);

      // Make port 0 the last grant, then contend port-1 write vs port-0 read
      bus.req0_i = 1'b1; bus.addr0_i = 32'h40;
      tick(); tick();
      chk("pre_ack0", 32'(bus.ack0_o), 32'h1);
      chk("pre_rdata0", bus.rdata0_o, 32'hC0DE0040);
      tick();
      bus.req0_i = 1'b0;
      bus.req1_i = 1'b1; bus.we1_i = 1'b1; bus.addr1_i = 32'h20; bus.wdata1_i = 32'h55;
      bus.req0_i = 1'b1; bus.we0_i = 1'b0; bus.addr0_i = 32'h20;
      tick();
      chk("ilv_p1_write", 32'(bus.mem_write_o), 32'h1);
      chk("ilv_addr", bus.mem_addr_o, 32'h20);
      chk("ilv_cnt", 32'(bus.conflict_cnt_o), 32'h3);
      tick();
      chk("ilv_ack1", {30'd0, bus.ack0_o, bus.ack1_o}, 32'h1);
      tick();
      chk("ilv_p0_read", 32'(bus.mem_read_o), 32'h1);
      bus.req1_i = 1'b0; bus.we1_i = 1'b0;
      tick();
      chk("ilv_ack0", {30'd0, bus.ack0_o, bus.ack1_o}, 32'h2);
      chk("ilv_rdata0", bus.rdata0_o, 32'h55);
      tick();
      bus.req0_i = 1'b0;

      // Saturation: 19 contended arbitrations from a count of 3
      bus.addr0_i = 32'h30; bus.addr1_i = 32'h34;
      for (int r = 0; r < 19; r++) begin
         serve_pair();
         if (r == 10) chk("sat_pre", 32'(bus.conflict_cnt_o), 32'd14);
      end
      chk("sat_stick", 32'(bus.conflict_cnt_o), 32'd15);
      chk("sat_rdata1", bus.rdata1_o, 32'hC0DE0034);

      // Reset in the ACCESS cycle of a port-1 read
      bus.req1_i = 1'b1; bus.we1_i = 1'b0; bus.addr1_i = 32'h50;
      tick();
      chk("mid_read", {30'd0, bus.mem_read_o, bus.busy_o}, 32'h3);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      bus.req1_i = 1'b0;
      chk("mid_ack1", 32'(bus.ack1_o), 32'h0);
      chk("mid_rdata1", bus.rdata1_o, 32'h0);
      chk("mid_idle", {30'd0, bus.mem_read_o, bus.busy_o}, 32'h0);
      chk("mid_cnt", 32'(bus.conflict_cnt_o), 32'h0);
      tick();
      chk("mid_no_ack", {30'd0, bus.ack0_o, bus.ack1_o}, 32'h0);
      bus.req1_i = 1'b1;
      tick(); tick();
      chk("post_ack1", 32'(bus.ack1_o), 32'h1);
      chk("post_rdata1", bus.rdata1_o, 32'hC0DE0050);
      tick();
      bus.req1_i = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single data-memory port between Pipe_CPU_1 (port 0) and Pipe_CPU_2 (port 1).
- Sits between each CPU's EX/MEM memory-request fields and Data_Memory.
- Serialises accesses with round-robin fairness, registers the memory command, returns read data plus a one-cycle ack to each requester.
- Counts contention cycles for performance reporting.

Parameters:
ADDR_W, 32, width of byte address passed to memory
DATA_W, 32, width of read/write data
CNT_W, 16, width of saturating contention counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
req0_i  in  1  port 0 access request; held until ack0_o seen
we0_i  in  1  port 0 op: 1=write, 0=read; stable while req0_i high
addr0_i  in  ADDR_W  port 0 byte address
wdata0_i  in  DATA_W  port 0 write data
ack0_o  out  1  one-cycle pulse: port 0 access complete
rdata0_o  out  DATA_W  port 0 read data, valid with ack0_o, held until next port-0 read ack
req1_i, we1_i, addr1_i, wdata1_i, ack1_o, rdata1_o  same as port 0, for port 1
mem_addr_o  out  ADDR_W  address to Data_Memory
mem_wdata_o  out  DATA_W  write data to Data_Memory
mem_read_o  out  1  read strobe to Data_Memory
mem_write_o  out  1  write strobe to Data_Memory
mem_rdata_i  in  DATA_W  combinational read data from Data_Memory
busy_o  out  1  high in ACCESS state
conflict_cnt_o  out  CNT_W  saturating count of arbitration cycles with both ports eligible

Behaviour:
- Reset (rst_i high at a rising edge): state=IDLE; all outputs 0; last_grant=1 so port 0 wins first tie; latched command cleared. Reset overrides every other event.
- States: IDLE, ACCESS, RESP.
- Eligibility: a port is eligible when its req is high. In RESP, the port being acked is masked, because its req may still be high.
- Arbitration in IDLE or RESP:
  - No eligible port: go or stay IDLE.
  - One eligible port: grant it.
  - Both eligible: grant the port != last_grant and increment conflict_cnt_o, saturating at all-ones.
  - On grant: latch addr, wdata, we and port id; set last_grant=port; next state ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr_o/mem_wdata_o driven from the latch.
  - mem_write_o = latched we; mem_read_o = !latched we; busy_o=1.
  - At the closing edge: for a read, mem_rdata_i is captured into rdataN_o of the granted port. The other port's rdata is unchanged. Next state RESP.
- RESP:
  - ackN_o=1 for the granted port only; mem strobes 0.
  - Arbitration runs as described, with the acked port masked.
- Strobes outside ACCESS: mem_read_o and mem_write_o are 0. mem_addr_o and mem_wdata_o hold their last values.
- Latency: request seen in IDLE -> ACCESS next cycle -> ack the cycle after. Two cycles from the first sampled req edge to ack. Sustained throughput is one access per 2 cycles.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1.
- Requester contract: deassert req, or present a new request, in the cycle after ack. Changing we/addr/wdata while req is high and un-acked is illegal. The arbiter latches at grant, so later changes do not affect the access in flight.
- Reset during ACCESS: the write strobe drops in the following cycle. No ack is issued and rdata is cleared. The write itself may already have committed at the reset edge, since memory writes on that edge.
- The arbiter does not check address range. Addresses are passed unchanged.
- Ack exclusivity: ack0_o and ack1_o are never high together.

Test Plan:
- Reset then idle: rst_i high 2 cycles, no req -> all outputs 0, state IDLE, mem strobes 0 for 10 cycles.
- Single write/read, port 0:
  - write addr 0x10, data 0x0000_00AB -> mem_write_o high exactly one cycle with addr 0x10, ack0_o pulses 2 cycles after req.
  - then read addr 0x10 -> rdata0_o=0xAB with ack0_o; ack1_o stays 0.
- Simultaneous requests:
  - both ports read from reset -> port 0 granted first, port 1 acked 2 cycles later; conflict_cnt_o=1.
  - hold both requesting 6 accesses -> grant order 0,1,0,1,0,1.
- Write/read interleave across ports:
  - port 1 writes 0x20=55 while port 0 reads 0x20 in the same cycle, after a previous port-0 grant (last_grant=0) -> port 1 wins.
  - port 0 then reads 55.
- Saturation: force 2^CNT_W+3 contended arbitrations (CNT_W=4 override: 19) -> conflict_cnt_o sticks at 15.
- Reset mid-ACCESS: assert rst_i in the ACCESS cycle of a port-1 read -> ack1_o never pulses, rdata1_o=0, state IDLE next cycle, and a new request after reset completes normally.
